// File: rtl/sti_deserializer.sv
// -----------------------------------------------------------------------------
// sti_deserializer
//
// Serial-to-parallel receiver for the STI serial stream (one bit per cycle with
// a valid strobe). It rebuilds the original 16-bit parallel word from a frame of
// 8, 16, 24 or 32 bits. It undoes bit order, byte select and zero-fill, and it
// flags nonzero fill bits. This block sits on the loopback/check path of the STI
// output, ahead of the memory-compare logic.
//
// Parameters
//   STRICT_GAP   1: si_valid low mid-frame drops the frame (po_abort pulse)
//                0: a gap pauses the frame; reception resumes on the next bit
//   FCNT_W       width of the completed-frame counter (wraps)
//
// Ports
//   clk          clock, rising edge
//   reset        asynchronous, active-high
//   cfg_length   frame size: 00=8, 01=16, 10=24, 11=32 bits
//   cfg_fill     24/32-bit frames: 0=data in low 16 bits, 1=data in high 16 bits
//   cfg_msb      1=frame word MSB sent first, 0=LSB first
//   cfg_low      8-bit frames: 0=byte is data[7:0], 1=byte is data[15:8]
//   si_data      serial data bit, qualified by si_valid
//   si_valid     serial bit strobe
//   po_data      reconstructed word, held until the next po_valid
//   po_valid     one-cycle pulse: po_data/po_fill_err updated
//   po_fill_err  fill bits of the completed frame were nonzero
//   po_abort     one-cycle pulse: frame dropped on a gap (STRICT_GAP=1 only)
//   busy         frame in progress
//   frame_cnt    completed-frame counter
// -----------------------------------------------------------------------------
module sti_deserializer #(
    parameter int STRICT_GAP = 1,
    parameter int FCNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        cfg_length,
    input  logic              cfg_fill,
    input  logic              cfg_msb,
    input  logic              cfg_low,
    input  logic              si_data,
    input  logic              si_valid,
    output logic [15:0]       po_data,
    output logic              po_valid,
    output logic              po_fill_err,
    output logic              po_abort,
    output logic              busy,
    output logic [FCNT_W-1:0] frame_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    state_t            state, state_n;
    logic [4:0]        cnt, cnt_n;
    logic [31:0]       w, w_n;
    logic [1:0]        len_q, len_n;
    logic              fill_q, fill_n;
    logic              msb_q, msb_n;
    logic              low_q, low_n;
    logic [15:0]       po_data_n;
    logic              po_fill_err_n;
    logic              po_valid_n;
    logic              po_abort_n;
    logic [FCNT_W-1:0] frame_cnt_n;

    // Effective frame configuration: the live cfg_* inputs in the cycle the
    // first bit arrives, the latched copy for the rest of the frame.
    logic              in_idle;
    logic [1:0]        len_e;
    logic              fill_e, msb_e, low_e;
    logic [4:0]        cnt_e, last_e, idx;
    logic [31:0]       w_cap;

    assign in_idle = (state == IDLE);
    assign len_e   = in_idle ? cfg_length : len_q;
    assign fill_e  = in_idle ? cfg_fill   : fill_q;
    assign msb_e   = in_idle ? cfg_msb    : msb_q;
    assign low_e   = in_idle ? cfg_low    : low_q;
    assign cnt_e   = in_idle ? 5'd0       : cnt;
    assign last_e  = {len_e, 3'b111};            // N-1 for N=(len+1)*8
    assign idx     = msb_e ? (last_e - cnt_e) : cnt_e;

    // The word is cleared implicitly when a frame starts, so each captured bit
    // is simply OR-ed into its slot. The completing bit is merged here too so
    // the output can be loaded on the same edge that captures it.
    assign w_cap   = (in_idle ? 32'd0 : w) | ({31'd0, si_data} << idx);

    function automatic logic [15:0] extract_data(input logic [1:0]  len,
                                                 input logic        fill,
                                                 input logic        low,
                                                 input logic [31:0] word);
        logic [15:0] d;
        case (len)
            2'b00:   d = low  ? {word[7:0], 8'h00} : {8'h00, word[7:0]};
            2'b01:   d = word[15:0];
            2'b10:   d = fill ? word[23:8]  : word[15:0];
            default: d = fill ? word[31:16] : word[15:0];
        endcase
        return d;
    endfunction

    function automatic logic extract_fill_err(input logic [1:0]  len,
                                              input logic        fill,
                                              input logic [31:0] word);
        logic e;
        case (len)
            2'b00, 2'b01: e = 1'b0;
            2'b10:        e = fill ? (|word[7:0])  : (|word[23:16]);
            default:      e = fill ? (|word[15:0]) : (|word[31:16]);
        endcase
        return e;
    endfunction

    always_comb begin
        state_n       = state;
        cnt_n         = cnt;
        w_n           = w;
        len_n         = len_q;
        fill_n        = fill_q;
        msb_n         = msb_q;
        low_n         = low_q;
        po_data_n     = po_data;
        po_fill_err_n = po_fill_err;
        po_valid_n    = 1'b0;
        po_abort_n    = 1'b0;
        frame_cnt_n   = frame_cnt;

        case (state)
            IDLE: begin
                if (si_valid) begin
                    state_n = RECV;
                    len_n   = cfg_length;
                    fill_n  = cfg_fill;
                    msb_n   = cfg_msb;
                    low_n   = cfg_low;
                    w_n     = w_cap;
                    cnt_n   = 5'd1;
                end
            end
            RECV: begin
                if (si_valid) begin
                    w_n = w_cap;
                    if (cnt == last_e) begin
                        state_n       = IDLE;
                        cnt_n         = 5'd0;
                        po_valid_n    = 1'b1;
                        po_data_n     = extract_data(len_e, fill_e, low_e, w_cap);
                        po_fill_err_n = extract_fill_err(len_e, fill_e, w_cap);
                        frame_cnt_n   = frame_cnt + FCNT_W'(1);
                    end else begin
                        cnt_n = cnt + 5'd1;
                    end
                end else if (STRICT_GAP != 0) begin
                    state_n    = IDLE;
                    cnt_n      = 5'd0;
                    po_abort_n = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= 5'd0;
            w           <= 32'd0;
            len_q       <= 2'b00;
            fill_q      <= 1'b0;
            msb_q       <= 1'b0;
            low_q       <= 1'b0;
            po_data     <= 16'd0;
            po_fill_err <= 1'b0;
            po_valid    <= 1'b0;
            po_abort    <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            w           <= w_n;
            len_q       <= len_n;
            fill_q      <= fill_n;
            msb_q       <= msb_n;
            low_q       <= low_n;
            po_data     <= po_data_n;
            po_fill_err <= po_fill_err_n;
            po_valid    <= po_valid_n;
            po_abort    <= po_abort_n;
            frame_cnt   <= frame_cnt_n;
        end
    end

    assign busy = (state == RECV);

endmodule

// File: tb/tb_sti_deserializer.sv
// -----------------------------------------------------------------------------
// tb_sti_deserializer
//
// Directed bench for sti_deserializer. Two instances share one stimulus stream:
// "s" with STRICT_GAP=1 and "g" with STRICT_GAP=0. Outputs are sampled 1 ns
// after the rising edge; expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_sti_deserializer;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  cfg_length;
    logic        cfg_fill, cfg_msb, cfg_low;
    logic        si_data, si_valid;

    logic [15:0] po_data_s, po_data_g;
    logic        po_valid_s, po_valid_g;
    logic        po_fill_err_s, po_fill_err_g;
    logic        po_abort_s, po_abort_g;
    logic        busy_s, busy_g;
    logic [15:0] frame_cnt_s, frame_cnt_g;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int c1, c2;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sti_deserializer #(.STRICT_GAP(1), .FCNT_W(16)) dut_s (
        .clk(clk), .reset(reset),
        .cfg_length(cfg_length), .cfg_fill(cfg_fill), .cfg_msb(cfg_msb), .cfg_low(cfg_low),
        .si_data(si_data), .si_valid(si_valid),
        .po_data(po_data_s), .po_valid(po_valid_s), .po_fill_err(po_fill_err_s),
        .po_abort(po_abort_s), .busy(busy_s), .frame_cnt(frame_cnt_s)
    );

    sti_deserializer #(.STRICT_GAP(0), .FCNT_W(16)) dut_g (
        .clk(clk), .reset(reset),
        .cfg_length(cfg_length), .cfg_fill(cfg_fill), .cfg_msb(cfg_msb), .cfg_low(cfg_low),
        .si_data(si_data), .si_valid(si_valid),
        .po_data(po_data_g), .po_valid(po_valid_g), .po_fill_err(po_fill_err_g),
        .po_abort(po_abort_g), .busy(busy_g), .frame_cnt(frame_cnt_g)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Sends frame bits [from, to) of an n-bit frame word in transmit order.
    task automatic send_bits(input logic [31:0] word, input int n, input logic msb,
                             input int from, input int to);
        for (int k = from; k < to; k++) begin
            si_valid = 1'b1;
            si_data  = msb ? word[n-1-k] : word[k];
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle_cycle();
        si_valid = 1'b0;
        si_data  = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input logic [1:0] len, input logic fill, input logic msb,
                           input logic low);
        cfg_length = len;
        cfg_fill   = fill;
        cfg_msb    = msb;
        cfg_low    = low;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        si_valid = 1'b0;
        si_data  = 1'b0;
        set_cfg(2'b01, 1'b0, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_po_data",   32'(po_data_s),   32'h0);
        check("rst_po_valid",  32'(po_valid_s),  32'h0);
        check("rst_fill_err",  32'(po_fill_err_s), 32'h0);
        check("rst_abort",     32'(po_abort_s),  32'h0);
        check("rst_busy",      32'(busy_s),      32'h0);
        check("rst_frame_cnt", 32'(frame_cnt_s), 32'h0);
        reset = 1'b0;
        idle_cycle();

        // 16-bit, MSB first
        set_cfg(2'b01, 1'b0, 1'b1, 1'b0);
        send_bits(32'hA5C3, 16, 1'b1, 0, 15);
        check("t1_busy_last", 32'(busy_s), 32'h1);
        send_bits(32'hA5C3, 16, 1'b1, 15, 16);
        check("t1_valid",    32'(po_valid_s),    32'h1);
        check("t1_data",     32'(po_data_s),     32'hA5C3);
        check("t1_fill_err", 32'(po_fill_err_s), 32'h0);
        check("t1_fcnt",     32'(frame_cnt_s),   32'h1);
        idle_cycle();
        check("t1_valid_pulse", 32'(po_valid_s), 32'h0);
        check("t1_data_hold",   32'(po_data_s),  32'hA5C3);

        // 8-bit, LSB first, byte to high half
        set_cfg(2'b00, 1'b0, 1'b0, 1'b1);
        send_bits(32'h3C, 8, 1'b0, 0, 8);
        check("t2_valid", 32'(po_valid_s),  32'h1);
        check("t2_data",  32'(po_data_s),   32'h3C00);
        check("t2_fcnt",  32'(frame_cnt_s), 32'h2);
        idle_cycle();

        // 8-bit, MSB first, byte to low half
        set_cfg(2'b00, 1'b0, 1'b1, 1'b0);
        send_bits(32'h5A, 8, 1'b1, 0, 8);
        check("t2b_data", 32'(po_data_s), 32'h005A);
        idle_cycle();

        // 24-bit, data low, clean fill then dirty fill
        set_cfg(2'b10, 1'b0, 1'b1, 1'b0);
        send_bits(32'h001234, 24, 1'b1, 0, 24);
        check("t3_data",     32'(po_data_s),     32'h1234);
        check("t3_fill_err", 32'(po_fill_err_s), 32'h0);
        idle_cycle();
        send_bits(32'h801234, 24, 1'b1, 0, 24);
        check("t3b_valid",    32'(po_valid_s),    32'h1);
        check("t3b_data",     32'(po_data_s),     32'h1234);
        check("t3b_fill_err", 32'(po_fill_err_s), 32'h1);
        idle_cycle();

        // 24-bit, data high, nonzero low fill byte
        set_cfg(2'b10, 1'b1, 1'b1, 1'b0);
        send_bits(32'hABCD01, 24, 1'b1, 0, 24);
        check("t3c_data",     32'(po_data_s),     32'hABCD);
        check("t3c_fill_err", 32'(po_fill_err_s), 32'h1);
        check("t3c_fcnt",     32'(frame_cnt_s),   32'h6);
        idle_cycle();

        // 32-bit, data high, LSB first, then back-to-back 16-bit frame
        set_cfg(2'b11, 1'b1, 1'b0, 1'b0);
        send_bits(32'hBEEF0000, 32, 1'b0, 0, 32);
        c1 = cyc;
        check("t4_valid",    32'(po_valid_s),    32'h1);
        check("t4_data",     32'(po_data_s),     32'hBEEF);
        check("t4_fill_err", 32'(po_fill_err_s), 32'h0);
        set_cfg(2'b01, 1'b0, 1'b1, 1'b0);
        send_bits(32'h0001, 16, 1'b1, 0, 16);
        c2 = cyc;
        check("t4b_valid",  32'(po_valid_s),  32'h1);
        check("t4b_data",   32'(po_data_s),   32'h0001);
        check("t4b_fcnt",   32'(frame_cnt_s), 32'h8);
        check("t4b_spacing", 32'(c2 - c1),    32'd16);
        idle_cycle();

        // Mid-frame gap: strict aborts, lenient pauses
        do_reset();
        set_cfg(2'b01, 1'b0, 1'b1, 1'b0);
        send_bits(32'hC35A, 16, 1'b1, 0, 5);
        idle_cycle();
        check("t5_abort_s", 32'(po_abort_s),  32'h1);
        check("t5_valid_s", 32'(po_valid_s),  32'h0);
        check("t5_busy_s",  32'(busy_s),      32'h0);
        check("t5_fcnt_s",  32'(frame_cnt_s), 32'h0);
        check("t5_abort_g", 32'(po_abort_g),  32'h0);
        check("t5_busy_g",  32'(busy_g),      32'h1);
        idle_cycle();
        check("t5_abort_pulse", 32'(po_abort_s), 32'h0);
        send_bits(32'hC35A, 16, 1'b1, 5, 16);
        check("t5_valid_g", 32'(po_valid_g),  32'h1);
        check("t5_data_g",  32'(po_data_g),   32'hC35A);
        check("t5_fcnt_g",  32'(frame_cnt_g), 32'h1);
        check("t5_novalid_s", 32'(po_valid_s), 32'h0);
        idle_cycle();

        // Reset in the middle of a frame
        do_reset();
        send_bits(32'h1111, 16, 1'b1, 0, 16);
        idle_cycle();
        send_bits(32'hFFFF, 16, 1'b1, 0, 10);
        #2 reset = 1'b1;
        #1;
        check("t6_rst_data", 32'(po_data_s),   32'h0);
        check("t6_rst_busy", 32'(busy_s),      32'h0);
        check("t6_rst_fcnt", 32'(frame_cnt_s), 32'h0);
        check("t6_rst_valid", 32'(po_valid_s), 32'h0);
        si_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle_cycle();
        send_bits(32'hFFFF, 16, 1'b1, 0, 16);
        check("t6_valid", 32'(po_valid_s),  32'h1);
        check("t6_data",  32'(po_data_s),   32'hFFFF);
        check("t6_fcnt",  32'(frame_cnt_s), 32'h1);
        idle_cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
